multi_tmr: RTL and testbench

- Parametrised N-channel successor to the single-channel timer driven by the `tmr_if` `controller`/`timer` signal set (`enable`, `mode`, `time_count`, `clear`, `done`).
- One shared prescaler produces a 1 µs tick from the system clock. N independent channels count down in µs, each in one-shot or auto-reload mode.
- Adds pause/resume, live remaining-count readback and per-channel busy status.
- Sits between the controller FSM and the blocks needing timed events, replacing per-block single timers.

---
 rtl/tmr_pkg.sv | 22 ++
 rtl/tmr_channel.sv | 99 +++++++++
 rtl/multi_tmr.sv | 96 +++++++++
 tb/tb_multi_tmr.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared types and constants for the multi-channel microsecond timer.
//   tmr_state_e   : channel FSM state (IDLE, RUN, EXPIRED)
//   tmr_mode_e    : channel mode (ONE_SHOT=0, AUTO_RELOAD=1)
//   TMR_US_HZ     : tick rate of the shared prescaler (1 MHz -> 1 us)
//   TMR_CNT_W_DEF : default channel counter width in us ticks
package tmr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } tmr_state_e;

  typedef enum logic {
    ONE_SHOT    = 1'b0,
    AUTO_RELOAD = 1'b1
  } tmr_mode_e;

  localparam int TMR_US_HZ     = 1_000_000;
  localparam int TMR_CNT_W_DEF = 24;

endpackage

// File: rtl/tmr_channel.sv
// One timer channel: IDLE/RUN/EXPIRED FSM plus a down-counter advanced by
// the shared 1 us tick.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   tick_i          : one-cycle strobe from the shared prescaler
//   enable_i        : level run request (low while in RUN pauses the count)
//   mode_i          : 0 one-shot, 1 auto-reload (sampled at expiry)
//   time_count_i    : period in ticks, sampled at load/reload (0 acts as 1)
//   clear_i         : synchronous clear to IDLE, wins over expiry
//   done_o          : registered one-cycle expiry pulse
//   remaining_o     : registered live down-counter value
//   state_o         : registered FSM state (debug / busy decode)
module tmr_channel
  import tmr_pkg::*;
#(
  parameter int CNT_W = TMR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] time_count_i,
  input  logic             clear_i,
  output logic             done_o,
  output logic [CNT_W-1:0] remaining_o,
  output tmr_state_e       state_o
);

  tmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] load_val;

  // A zero period would never expire from a down-counter, so it loads as 1.
  assign load_val = (time_count_i == '0) ? CNT_W'(1) : time_count_i;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (clear_i) begin
      // Clear suppresses a coincident expiry entirely (no done pulse).
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            rem_d   = load_val;
            state_d = RUN;
          end
        end
        RUN: begin
          // enable low holds the count; ticks are simply ignored.
          if (enable_i && tick_i) begin
            if (rem_q > CNT_W'(1)) begin
              rem_d = rem_q - CNT_W'(1);
            end else begin
              done_d = 1'b1;
              // Reload on the expiry tick itself so the period has no drift.
              if (tmr_mode_e'(mode_i) == AUTO_RELOAD) begin
                rem_d = load_val;
              end else begin
                rem_d   = '0;
                state_d = EXPIRED;
              end
            end
          end
        end
        EXPIRED: begin
          // Needs enable to drop before another one-shot can start.
          if (!enable_i) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign done_o      = done_q;
  assign remaining_o = rem_q;
  assign state_o     = state_q;

endmodule

// File: rtl/multi_tmr.sv
// N-channel microsecond timer with one shared prescaler.
// Optional interrupt aggregation is built when MULTI_TMR_IRQ_EN is defined.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   enable       : per-channel level run request
//   mode         : per-channel mode (0 one-shot, 1 auto-reload)
//   time_count   : per-channel period, channel i at [i*CNT_W +: CNT_W]
//   clear        : per-channel synchronous clear
//   done         : per-channel one-cycle expiry pulse
//   busy         : per-channel 1 while in RUN (including paused)
//   remaining    : per-channel live down-counter value
//   irq_ack      : (MULTI_TMR_IRQ_EN) per-channel pending acknowledge
//   irq_pending  : (MULTI_TMR_IRQ_EN) sticky per-channel expiry flags
//   irq          : (MULTI_TMR_IRQ_EN) registered OR of irq_pending
module multi_tmr
  import tmr_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = TMR_CNT_W_DEF,
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       enable,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH*CNT_W-1:0] time_count,
  input  logic [N_CH-1:0]       clear,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH*CNT_W-1:0] remaining
`ifdef MULTI_TMR_IRQ_EN
  ,
  input  logic [N_CH-1:0]       irq_ack,
  output logic [N_CH-1:0]       irq_pending,
  output logic                  irq
`endif
);

  localparam int TICK_DIV = CLK_FREQ_HZ / TMR_US_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Free-running prescaler; channels never restart it, so the first us
  // after a start may be short by up to TICK_DIV-1 clocks.
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  tmr_state_e ch_state [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tmr_channel #(.CNT_W(CNT_W)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (tick),
      .enable_i     (enable[i]),
      .mode_i       (mode[i]),
      .time_count_i (time_count[i*CNT_W +: CNT_W]),
      .clear_i      (clear[i]),
      .done_o       (done[i]),
      .remaining_o  (remaining[i*CNT_W +: CNT_W]),
      .state_o      (ch_state[i])
    );
    // Decode of a registered state only, so busy carries no input path.
    assign busy[i] = (ch_state[i] == RUN);
  end

`ifdef MULTI_TMR_IRQ_EN
  logic [N_CH-1:0] pend_q, pend_d;
  logic            irq_q;

  // A new done pulse beats a coincident ack; clear beats both.
  assign pend_d = ((pend_q & ~irq_ack) | done) & ~clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_d;
    end
  end

  assign irq_pending = pend_q;
  assign irq         = irq_q;
`endif

endmodule

// File: tb/tb_multi_tmr.sv
// Self-checking bench for multi_tmr at CLK_FREQ_HZ=4 MHz (4 clocks per us).
// Expected done edges come from a bench-side prescaler model and are queued
// when a channel is started; every negedge the queued edges due now are
// popped and compared with the done vector.
module tb_multi_tmr;

  localparam int N_CH  = 4;
  localparam int CNT_W = 24;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       enable, mode, clear;
  logic [N_CH*CNT_W-1:0] time_count;
  logic [N_CH-1:0]       done, busy;
  logic [N_CH*CNT_W-1:0] remaining;
`ifdef MULTI_TMR_IRQ_EN
  logic [N_CH-1:0]       irq_ack, irq_pending;
  logic                  irq;
`endif

  multi_tmr #(.N_CH(N_CH), .CNT_W(CNT_W), .CLK_FREQ_HZ(4_000_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .time_count (time_count),
    .clear      (clear),
    .done       (done),
    .busy       (busy),
    .remaining  (remaining)
`ifdef MULTI_TMR_IRQ_EN
    ,
    .irq_ack     (irq_ack),
    .irq_pending (irq_pending),
    .irq         (irq)
`endif
  );

  // ---------------- clock / reset / prescaler model ----------------
  always #5 clk = ~clk;

  int cyc     = 0;  // number of rising edges so far
  int presc_m = 0;  // model of the prescaler register

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) presc_m <= 0;
    else     presc_m <= (presc_m == 3) ? 0 : presc_m + 1;
  end

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];  // {channel, expected done edge}
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input int edge_n);
    exp_q.push_back({8'(ch), 32'(edge_n)});
  endtask

  task automatic mon();
    logic [N_CH-1:0] mask;
    mask = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (int'(exp_q[i][31:0]) <= cyc) begin
        if (int'(exp_q[i][31:0]) == cyc) begin
          mask[exp_q[i][33:32]] = 1'b1;
        end else begin
          n_checks++;
          n_err++;
          $display("FAIL sb_missed: ch%0d expected at edge %0d, now %0d",
                   exp_q[i][39:32], exp_q[i][31:0], cyc);
        end
        exp_q.delete(i);
      end
    end
    if (mask != '0 || done != '0) chk("done_vec", {92'd0, done}, {92'd0, mask});
  endtask

  // All time advances through step so the monitor sees every negedge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      mon();
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step(1);
  endtask

  // Edge at which the k-th counted tick lands, for inputs applied now
  // (sampled at edge cyc+1). A start from IDLE cannot count a tick on the
  // load edge; a resume from pause can.
  function automatic int exp_edge(input int k, input bit incl_now);
    int j;
    j = (3 - presc_m + 4) % 4;
    if (!incl_now && j == 0) j = 4;
    return cyc + 1 + j + 4 * (k - 1);
  endfunction

  function automatic logic [CNT_W-1:0] rem(input int ch);
    return remaining[ch*CNT_W +: CNT_W];
  endfunction

  task automatic set_tc(input int ch, input int v);
    time_count[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  // ---------------- one-shot vector table ----------------
  typedef struct {
    int   ch;
    logic md;
    int   tc;
    int   exp_ticks;
    int   exp_load;
  } vec_t;

  vec_t vec[5];

  initial begin
    int ch, t, t_last, n;

    vec[0] = '{0, 1'b0, 5, 5, 5};
    vec[1] = '{3, 1'b0, 0, 1, 1};
    vec[2] = '{2, 1'b0, 1, 1, 1};
    vec[3] = '{1, 1'b0, 7, 7, 7};
    vec[4] = '{3, 1'b0, $urandom_range(2, 9), 0, 0};
    vec[4].exp_ticks = vec[4].tc;
    vec[4].exp_load  = vec[4].tc;

    rst = 1'b1; enable = '0; mode = '0; clear = '0; time_count = '0;
`ifdef MULTI_TMR_IRQ_EN
    irq_ack = '0;
`endif
    step(3);
    chk("rst_done", {92'd0, done}, 96'd0);
    chk("rst_busy", {92'd0, busy}, 96'd0);
    chk("rst_remaining", remaining, 96'd0);
`ifdef MULTI_TMR_IRQ_EN
    chk("rst_irq", {91'd0, irq, irq_pending}, 96'd0);
`endif
    rst = 1'b0;
    step(2);

    // One-shot vectors: load value, exact expiry edge, idle-after, no retrigger.
    for (int v = 0; v < 5; v++) begin
      ch = vec[v].ch;
      mode[ch] = vec[v].md;
      set_tc(ch, vec[v].tc);
      enable[ch] = 1'b1;
      t = exp_edge(vec[v].exp_ticks, 1'b0);
      push(ch, t);
      step(1);
      chk("os_load_rem", 96'(rem(ch)), 96'(vec[v].exp_load));
      chk("os_load_busy", 96'(busy[ch]), 96'd1);
      wait_cyc(t);
      step(1);
      chk("os_end_busy", 96'(busy[ch]), 96'd0);
      chk("os_end_rem", 96'(rem(ch)), 96'd0);
      step(100);
      chk("os_hold_busy", 96'(busy[ch]), 96'd0);
      enable[ch] = 1'b0;
      step(2);
    end

    // Auto-reload: ten periods of exactly 12 clocks.
    mode[1] = 1'b1;
    set_tc(1, 3);
    enable[1] = 1'b1;
    t_last = 0;
    for (int k = 1; k <= 10; k++) begin
      t_last = exp_edge(3 * k, 1'b0);
      push(1, t_last);
    end
    step(1);
    wait_cyc(t_last);
    chk("ar_busy", 96'(busy[1]), 96'd1);
    chk("ar_reload_rem", 96'(rem(1)), 96'd3);
    enable[1] = 1'b0;
    step(20);
    chk("ar_pause_busy", 96'(busy[1]), 96'd1);
    chk("ar_pause_rem", 96'(rem(1)), 96'd3);
    clear[1] = 1'b1;
    step(1);
    clear[1] = 1'b0;
    chk("ar_clear_busy", 96'(busy[1]), 96'd0);
    chk("ar_clear_rem", 96'(rem(1)), 96'd0);
    mode[1] = 1'b0;
    step(2);

    // Pause at remaining=6 for 40 clocks, then resume without reload.
    set_tc(2, 10);
    enable[2] = 1'b1;
    step(1);
    n = 0;
    while (rem(2) != CNT_W'(6) && n < 200) begin
      step(1);
      n++;
    end
    chk("pause_reach6", 96'(rem(2)), 96'd6);
    enable[2] = 1'b0;
    step(40);
    chk("pause_hold_rem", 96'(rem(2)), 96'd6);
    chk("pause_hold_busy", 96'(busy[2]), 96'd1);
    enable[2] = 1'b1;
    t = exp_edge(6, 1'b1);
    push(2, t);
    wait_cyc(t);
    step(1);
    chk("resume_end_busy", 96'(busy[2]), 96'd0);
    enable[2] = 1'b0;
    step(2);

    // Clear coincident with the expiry tick: no done, IDLE, then reload.
    set_tc(0, 3);
    enable[0] = 1'b1;
    t = exp_edge(3, 1'b0);
    step(1);
    while (cyc < t - 1) step(1);
    clear[0] = 1'b1;
    step(1);
    chk("clr_no_done", 96'(done[0]), 96'd0);
    chk("clr_busy", 96'(busy[0]), 96'd0);
    chk("clr_rem", 96'(rem(0)), 96'd0);
    clear[0] = 1'b0;
    step(1);
    chk("clr_reload_busy", 96'(busy[0]), 96'd1);
    chk("clr_reload_rem", 96'(rem(0)), 96'd3);
    enable[0] = 1'b0;
    step(1);
    clear[0] = 1'b1;
    step(1);
    clear[0] = 1'b0;
    step(2);

    // Reset mid-count at remaining=7: everything zero, no done.
    set_tc(0, 10);
    enable[0] = 1'b1;
    step(1);
    n = 0;
    while (rem(0) != CNT_W'(7) && n < 200) begin
      step(1);
      n++;
    end
    chk("rstmid_reach7", 96'(rem(0)), 96'd7);
    rst = 1'b1;
    enable[0] = 1'b0;
    step(1);
    chk("rstmid_done", {92'd0, done}, 96'd0);
    chk("rstmid_busy", {92'd0, busy}, 96'd0);
    chk("rstmid_remaining", remaining, 96'd0);
    rst = 1'b0;
    step(2);

    // All four channels expire on the same edge.
    mode = '0;
    for (int c = 0; c < N_CH; c++) set_tc(c, 2);
    enable = 4'hF;
    t = exp_edge(2, 1'b0);
    for (int c = 0; c < N_CH; c++) push(c, t);
    step(1);
    wait_cyc(t);
    chk("simul_done", {92'd0, done}, 96'hF);
    step(1);
    chk("simul_busy", {92'd0, busy}, 96'd0);
    enable = '0;
    step(2);

`ifdef MULTI_TMR_IRQ_EN
    // Interrupt pending: set by done, survives a coincident ack, lone ack clears.
    mode[0] = 1'b1;
    set_tc(0, 2);
    enable[0] = 1'b1;
    t = exp_edge(2, 1'b0);
    t_last = exp_edge(4, 1'b0);
    push(0, t);
    push(0, t_last);
    step(1);
    wait_cyc(t);
    step(1);
    chk("irq_pend_set", 96'(irq_pending[0]), 96'd1);
    chk("irq_set", 96'(irq), 96'd1);
    wait_cyc(t_last);
    irq_ack[0] = 1'b1;
    step(1);
    irq_ack[0] = 1'b0;
    chk("irq_ack_vs_set", 96'(irq_pending[0]), 96'd1);
    enable[0] = 1'b0;
    step(1);
    irq_ack[0] = 1'b1;
    step(1);
    irq_ack[0] = 1'b0;
    chk("irq_ack_pend", 96'(irq_pending[0]), 96'd0);
    chk("irq_ack_irq", 96'(irq), 96'd0);
    clear[0] = 1'b1;
    step(1);
    clear[0] = 1'b0;
    mode[0] = 1'b0;
    step(2);
`endif

    step(5);
    chk("sb_empty", 96'(exp_q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
